// File: rtl/triangle_list.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : triangle_list                                                 |
// | Purpose  : triangle store; replays the list to the transform stage once  |
// |            per frame over valid/ready. Optional TRI_LIST_FRAMECNT_EN     |
// |            adds a 16-bit completed-frame counter (frame_cnt).            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module triangle_list #(
   parameter int WI    = 8,
   parameter int WF    = 8,
   parameter int DEPTH = 16
) (
   input  logic                                Clk,
   input  logic                                Reset,
   input  logic                                clear,
   input  logic                                list_w,
   input  logic [2:0][2:0][WI+WF-1:0]          orig_triangle_in,
   input  logic                                frame_start,
   output logic [2:0][2:0][WI+WF-1:0]          tri_out,
   output logic                                tri_valid,
   input  logic                                tri_ready,
   output logic                                tri_last,
   output logic                                frame_done,
   output logic [$clog2(DEPTH+1)-1:0]          tri_count,
   output logic                                overflow
`ifdef TRI_LIST_FRAMECNT_EN
   ,
   output logic [15:0]                         frame_cnt
`endif
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);

   typedef logic [2:0][2:0][WI+WF-1:0] tri_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      OUT  = 2'd2,
      DONE = 2'd3
   } state_t;

   tri_t            r_mem [DEPTH];
   logic [CW-1:0]   r_count;
   logic            r_overflow;
   logic [CW-1:0]   r_n;
   logic [AW-1:0]   r_rd_ptr;
   state_t          r_state;
   tri_t            r_tri_out;
   logic            r_tri_valid;
   logic            r_tri_last;
   logic            r_frame_done;

   logic            w_full;
   logic            w_wr_en;
   logic            w_last;

   assign w_full  = (r_count == c_DEPTH);
   assign w_wr_en = list_w && !clear && !Reset && !w_full;
   assign w_last  = (CW'(r_rd_ptr) == (r_n - 1'b1));

   // Write side runs regardless of traversal; clear wins over a same-cycle write.
   always_ff @(posedge Clk) begin
      if (Reset || clear) begin
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (list_w) begin
         if (w_full)
            r_overflow <= 1'b1;
         else
            r_count <= r_count + 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (w_wr_en)
         r_mem[r_count[AW-1:0]] <= orig_triangle_in;
   end

   // tri_out doubles as the synchronous read register of the storage array.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state      <= IDLE;
         r_n          <= '0;
         r_rd_ptr     <= '0;
         r_tri_out    <= '0;
         r_tri_valid  <= 1'b0;
         r_tri_last   <= 1'b0;
         r_frame_done <= 1'b0;
      end else if (clear) begin
         r_state      <= IDLE;
         r_rd_ptr     <= '0;
         r_tri_valid  <= 1'b0;
         r_tri_last   <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_frame_done <= 1'b0;
               if (frame_start) begin
                  r_n <= r_count;
                  if (r_count == '0) begin
                     r_state      <= DONE;
                     r_frame_done <= 1'b1;
                  end else begin
                     r_rd_ptr <= '0;
                     r_state  <= RD;
                  end
               end
            end
            RD: begin
               r_tri_out   <= r_mem[r_rd_ptr];
               r_tri_valid <= 1'b1;
               r_tri_last  <= w_last;
               r_state     <= OUT;
            end
            OUT: begin
               if (tri_ready) begin
                  r_tri_valid <= 1'b0;
                  r_tri_last  <= 1'b0;
                  if (r_tri_last) begin
                     r_state      <= DONE;
                     r_frame_done <= 1'b1;
                  end else begin
                     r_rd_ptr <= r_rd_ptr + 1'b1;
                     r_state  <= RD;
                  end
               end
            end
            DONE: begin
               r_frame_done <= 1'b0;
               r_state      <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

`ifdef TRI_LIST_FRAMECNT_EN
   logic [15:0] r_frame_cnt;

   always_ff @(posedge Clk) begin
      if (Reset)
         r_frame_cnt <= '0;
      else if (r_frame_done)
         r_frame_cnt <= r_frame_cnt + 16'd1;
   end

   assign frame_cnt = r_frame_cnt;
`endif

   assign tri_out    = r_tri_out;
   assign tri_valid  = r_tri_valid;
   assign tri_last   = r_tri_last;
   assign frame_done = r_frame_done;
   assign tri_count  = r_count;
   assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: doc/triangle_list.md
Name: triangle_list

Overview:
- Triangle storage buffer that sits directly downstream of the object loader (list writer).
- Captures model-space triangles presented with the list_w strobe and holds them across frames.
- On each frame_start, replays the stored triangles in write order to the transform stage over a valid/ready handshake, then pulses frame_done.

Parameters:
WI, 8, integer bits per fixed-point coordinate
WF, 8, fractional bits per fixed-point coordinate
DEPTH, 16, maximum stored triangles (power of two, >=2)

Ports:
Clk  input  1  clock
Reset  input  1  reset
clear  input  1  empty the list, abort any traversal
list_w  input  1  write strobe: store orig_triangle_in this cycle
orig_triangle_in  input  [2:0][2:0][WI+WF-1:0]  triangle {V0,V1,V2}, each vertex {x,y,z}
frame_start  input  1  begin one traversal of the stored list
tri_out  output  [2:0][2:0][WI+WF-1:0]  triangle being presented
tri_valid  output  1  tri_out valid
tri_ready  input  1  consumer accepts tri_out
tri_last  output  1  tri_out is the final triangle of this traversal
frame_done  output  1  one-cycle pulse at end of traversal
tri_count  output  $clog2(DEPTH+1)  triangles currently stored
overflow  output  1  sticky: a write was dropped because the list was full

Behaviour:
- Reset (Reset, synchronous, active-high; clock Clk) applies to all outputs; count, read pointer, overflow, tri_valid, tri_last, frame_done = 0; tri_out = 0; FSM = IDLE. Storage contents are not reset.
- Write side, independent of FSM:
  - list_w with count<DEPTH: store at index count, count+1 next cycle.
  - list_w with count==DEPTH: write dropped, overflow<=1.
  - overflow is cleared only by Reset or clear.
  - tri_count = count, registered.
- clear: count<=0, overflow<=0, FSM->IDLE, tri_valid/tri_last<=0, no frame_done. clear has priority over a same-cycle list_w (write dropped) and over frame_start.
- Storage is a synchronous-read array (block-RAM inferable) with 1-cycle read latency.
- FSM states IDLE, RD, OUT, DONE:
  - IDLE, frame_start: snapshot n=count. If n==0, go to DONE. Otherwise rd_ptr<=0 and go to RD.
  - RD: address=rd_ptr. Go to OUT, where the next cycle registers tri_out=mem[rd_ptr], tri_valid=1, and tri_last=(rd_ptr==n-1).
  - OUT: hold tri_out/tri_valid/tri_last stable until tri_ready. On the accepting cycle, tri_valid<=0 next cycle. If last, go to DONE; otherwise rd_ptr+1 and go to RD.
  - DONE: frame_done=1 for exactly one cycle, then IDLE.
  - frame_start outside IDLE is ignored.
- Throughput is one triangle per 2 cycles with tri_ready held high. Latency from frame_start to first tri_valid is 2 cycles.
- Writes during traversal are accepted but not replayed until the next frame, because the snapshot n is fixed for the current traversal.
- Reading index i while the writer writes index count (>i) in the same cycle is legal. No read-during-write hazard exists since i<n<=count.

Optional Feature:
TRI_LIST_FRAMECNT_EN
- Defined: adds output frame_cnt [15:0], reset 0. It increments in the cycle after each frame_done pulse (including n==0 frames) and wraps from 16'hFFFF to 0. clear does not reset it.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then write 12 cube triangles with list_w (first {fc00fc00fc00, fc00fc000100, fc000100fc00}) -> tri_count=12, overflow=0.
- frame_start, tri_ready=1 -> 12 triangles out in write order, tri_valid every other cycle, first valid 2 cycles after start, tri_last only on the 12th, frame_done 1 cycle after final accept, second frame identical.
- Backpressure: tri_ready low for 5 cycles on triangle 3 -> tri_out/tri_valid stable for all 5 cycles, no skip or duplicate, 12 triangles delivered.
- DEPTH=16, 17 writes -> tri_count=16, overflow=1, 17th triangle absent in traversal. clear -> tri_count=0, overflow=0.
- Empty list, frame_start -> no tri_valid, frame_done 1 cycle after start. clear mid-traversal at triangle 5 -> tri_valid drops next cycle, no frame_done.
- With TRI_LIST_FRAMECNT_EN: 3 frames -> frame_cnt=3. clear/list_w collision -> tri_count=0.
